// File: rtl/split_mfft_to_two_sfft_if.sv
// Bundle for the splitter: serial sample input with ready/valid, per-sub-FFT frame-ready inputs,
// and the two aligned half-frame output streams.
interface split_mfft_to_two_sfft_if #(
    parameter int unsigned SIZE_BUFFER = 4,
    parameter int unsigned SIZE_DATA   = 16
);
    localparam int unsigned CNT_W = (SIZE_BUFFER > 1) ? SIZE_BUFFER - 1 : 1;

    logic [SIZE_DATA-1:0] i_data_i;
    logic [SIZE_DATA-1:0] i_data_q;
    logic                 i_valid;
    logic                 o_ready;
    logic                 i_resive_chet;
    logic                 i_resive_Nchet;
    logic [SIZE_DATA-1:0] o_data_chet_i;
    logic [SIZE_DATA-1:0] o_data_chet_q;
    logic [SIZE_DATA-1:0] o_data_Nchet_i;
    logic [SIZE_DATA-1:0] o_data_Nchet_q;
    logic                 o_flag_complete_chet;
    logic                 o_flag_complete_Nchet;
    logic [CNT_W-1:0]     o_counterSendData;
    logic                 o_overflow;

    modport master (
        output i_data_i, i_data_q, i_valid, i_resive_chet, i_resive_Nchet,
        input  o_ready, o_data_chet_i, o_data_chet_q, o_data_Nchet_i, o_data_Nchet_q,
               o_flag_complete_chet, o_flag_complete_Nchet, o_counterSendData, o_overflow
    );

    modport slave (
        input  i_data_i, i_data_q, i_valid, i_resive_chet, i_resive_Nchet,
        output o_ready, o_data_chet_i, o_data_chet_q, o_data_Nchet_i, o_data_Nchet_q,
               o_flag_complete_chet, o_flag_complete_Nchet, o_counterSendData, o_overflow
    );
endinterface

// File: rtl/split_mfft_to_two_sfft.sv
// Decimation-in-time splitter: de-interleaves an NFFT-sample stream into even/odd half frames,
// double-buffered so one bank fills while the other streams to both sub-FFTs.
module split_mfft_to_two_sfft #(
    parameter int unsigned SIZE_BUFFER = 4,
    parameter int unsigned SIZE_DATA   = 16
) (
    input logic                     i_clk,
    input logic                     i_reset,
    split_mfft_to_two_sfft_if.slave bus
);
    localparam int unsigned NFFT   = 1 << SIZE_BUFFER;
    localparam int unsigned HALF   = NFFT / 2;
    localparam int unsigned CNT_W  = (SIZE_BUFFER > 1) ? SIZE_BUFFER - 1 : 1;
    localparam int unsigned WORD_W = 2 * SIZE_DATA;

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    state_e                 r_state;
    logic [1:0]             r_full;
    logic [1:0]             w_full_d;
    logic                   r_wr_bank;
    logic                   r_rd_bank;
    logic                   w_wr_bank_d;
    logic [SIZE_BUFFER-1:0] r_wr_cnt;
    logic [CNT_W-1:0]       r_rd_idx;
    logic [CNT_W-1:0]       w_rd_idx_n;
    logic                   r_ready;
    logic                   r_overflow;
    logic                   r_flag;
    logic [SIZE_DATA-1:0]   r_out_ci;
    logic [SIZE_DATA-1:0]   r_out_cq;
    logic [SIZE_DATA-1:0]   r_out_ni;
    logic [SIZE_DATA-1:0]   r_out_nq;
    logic [CNT_W-1:0]       r_out_cnt;
    logic [WORD_W-1:0]      r_mem_chet  [NFFT];
    logic [WORD_W-1:0]      r_mem_nchet [NFFT];
    logic [WORD_W-1:0]      r_rd_chet;
    logic [WORD_W-1:0]      r_rd_nchet;
    logic                   w_accept;
    logic                   w_last_wr;
    logic                   w_start;
    logic                   w_last_rd;
    logic                   w_rd_en;
    logic [SIZE_BUFFER-1:0] w_waddr;
    logic [SIZE_BUFFER-1:0] w_raddr;

    assign w_accept  = bus.i_valid & r_ready;
    assign w_last_wr = w_accept & (r_wr_cnt == SIZE_BUFFER'(NFFT - 1));
    assign w_start   = (r_state == StIdle) & r_full[r_rd_bank]
                     & bus.i_resive_chet & bus.i_resive_Nchet;
    assign w_last_rd = (r_state == StSend) & (r_rd_idx == CNT_W'(HALF - 1));
    // RAM read runs one word ahead of the output registers
    assign w_rd_en    = w_start | ((r_state == StSend) & ~w_last_rd);
    assign w_rd_idx_n = w_start ? '0 : r_rd_idx + CNT_W'(1);

    // Bank bit on top, word index within the half below it
    assign w_waddr = (SIZE_BUFFER'(r_wr_bank) << (SIZE_BUFFER - 1)) | (r_wr_cnt >> 1);
    assign w_raddr = (SIZE_BUFFER'(r_rd_bank) << (SIZE_BUFFER - 1)) | SIZE_BUFFER'(w_rd_idx_n);

    assign w_wr_bank_d = r_wr_bank ^ w_last_wr;

    always_comb begin
        w_full_d = r_full;
        if (w_last_wr) w_full_d[r_wr_bank] = 1'b1;
        if (w_last_rd) w_full_d[r_rd_bank] = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (w_accept & ~r_wr_cnt[0]) r_mem_chet[w_waddr] <= {bus.i_data_i, bus.i_data_q};
        if (w_accept & r_wr_cnt[0]) r_mem_nchet[w_waddr] <= {bus.i_data_i, bus.i_data_q};
        if (w_rd_en) begin
            r_rd_chet  <= r_mem_chet[w_raddr];
            r_rd_nchet <= r_mem_nchet[w_raddr];
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state    <= StIdle;
            r_full     <= '0;
            r_wr_bank  <= 1'b0;
            r_rd_bank  <= 1'b0;
            r_wr_cnt   <= '0;
            r_rd_idx   <= '0;
            r_ready    <= 1'b1;
            r_overflow <= 1'b0;
            r_flag     <= 1'b0;
            r_out_ci   <= '0;
            r_out_cq   <= '0;
            r_out_ni   <= '0;
            r_out_nq   <= '0;
            r_out_cnt  <= '0;
        end else begin
            r_full    <= w_full_d;
            r_wr_bank <= w_wr_bank_d;
            // A bank freed by SEND is seen here one cycle late, so o_ready rises after the burst
            r_ready   <= ~r_full[w_wr_bank_d];
            if (w_accept) r_wr_cnt <= r_wr_cnt + SIZE_BUFFER'(1);
            if (bus.i_valid & ~r_ready) r_overflow <= 1'b1;
            unique case (r_state)
                StIdle: begin
                    r_flag <= 1'b0;
                    if (w_start) begin
                        r_state  <= StSend;
                        r_rd_idx <= '0;
                    end
                end
                StSend: begin
                    r_flag    <= 1'b1;
                    r_out_ci  <= r_rd_chet[WORD_W-1:SIZE_DATA];
                    r_out_cq  <= r_rd_chet[SIZE_DATA-1:0];
                    r_out_ni  <= r_rd_nchet[WORD_W-1:SIZE_DATA];
                    r_out_nq  <= r_rd_nchet[SIZE_DATA-1:0];
                    r_out_cnt <= r_rd_idx;
                    if (w_last_rd) begin
                        r_state   <= StIdle;
                        r_rd_bank <= ~r_rd_bank;
                    end else begin
                        r_rd_idx <= w_rd_idx_n;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.o_ready               = r_ready;
    assign bus.o_overflow            = r_overflow;
    assign bus.o_flag_complete_chet  = r_flag;
    assign bus.o_flag_complete_Nchet = r_flag;
    assign bus.o_data_chet_i         = r_out_ci;
    assign bus.o_data_chet_q         = r_out_cq;
    assign bus.o_data_Nchet_i        = r_out_ni;
    assign bus.o_data_Nchet_q        = r_out_nq;
    assign bus.o_counterSendData     = r_out_cnt;
endmodule

// File: tb/tb_split_mfft_to_two_sfft.sv
// Directed bench for the DIT splitter: NFFT=16 instance for framing/buffering scenarios and an
// NFFT=2 instance for the single-word burst case.
module tb_split_mfft_to_two_sfft;
    localparam int unsigned SD = 16;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    split_mfft_to_two_sfft_if #(.SIZE_BUFFER(4), .SIZE_DATA(SD)) bus4 ();
    split_mfft_to_two_sfft_if #(.SIZE_BUFFER(1), .SIZE_DATA(SD)) bus1 ();

    split_mfft_to_two_sfft #(.SIZE_BUFFER(4), .SIZE_DATA(SD)) u_dut4 (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (bus4)
    );

    split_mfft_to_two_sfft #(.SIZE_BUFFER(1), .SIZE_DATA(SD)) u_dut1 (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (bus1)
    );

    // Captured burst from the NFFT=16 instance
    logic [SD-1:0] cap_ci [8];
    logic [SD-1:0] cap_cq [8];
    logic [SD-1:0] cap_ni [8];
    logic [SD-1:0] cap_nq [8];
    logic [2:0]    cap_cnt [8];
    int            cap_n, cap_start, cap_end, cap_flag_neq;
    logic          cap_to, cap_rdy_last, cap_rdy_after;

    task automatic stream4(input int base, input int n, output int last_cyc);
        @(posedge clk); #1;
        for (int k = 0; k < n; k++) begin
            bus4.i_data_i = SD'(base + k);
            bus4.i_data_q = SD'(-(base + k));
            bus4.i_valid  = 1'b1;
            @(posedge clk); #1;
        end
        bus4.i_valid = 1'b0;
        last_cyc = cyc;
    endtask

    task automatic capture_burst(input int budget);
        int w;
        w = 0;
        cap_n = 0;
        cap_flag_neq = 0;
        cap_to = 1'b0;
        @(negedge clk);
        while (!bus4.o_flag_complete_chet && w < budget) begin
            @(negedge clk);
            w++;
        end
        if (!bus4.o_flag_complete_chet) begin
            cap_to = 1'b1;
            return;
        end
        cap_start = cyc;
        while (bus4.o_flag_complete_chet && cap_n <= 16) begin
            if (cap_n < 8) begin
                cap_ci[cap_n]  = bus4.o_data_chet_i;
                cap_cq[cap_n]  = bus4.o_data_chet_q;
                cap_ni[cap_n]  = bus4.o_data_Nchet_i;
                cap_nq[cap_n]  = bus4.o_data_Nchet_q;
                cap_cnt[cap_n] = bus4.o_counterSendData;
            end
            if (bus4.o_flag_complete_Nchet !== bus4.o_flag_complete_chet) cap_flag_neq++;
            cap_rdy_last = bus4.o_ready;
            cap_end = cyc;
            cap_n++;
            @(negedge clk);
        end
        cap_rdy_after = bus4.o_ready;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus4.i_valid = 1'b0; bus4.i_data_i = '0; bus4.i_data_q = '0;
        bus4.i_resive_chet = 1'b0; bus4.i_resive_Nchet = 1'b0;
        bus1.i_valid = 1'b0; bus1.i_data_i = '0; bus1.i_data_q = '0;
        bus1.i_resive_chet = 1'b0; bus1.i_resive_Nchet = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus4.o_ready !== 1'b1 || bus4.o_overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_ovf got %b%b want 10", bus4.o_ready, bus4.o_overflow);
        end
        checks++;
        if (bus4.o_flag_complete_chet !== 1'b0 || bus4.o_flag_complete_Nchet !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got %b%b want 00", bus4.o_flag_complete_chet,
                     bus4.o_flag_complete_Nchet);
        end
        checks++;
        if (bus4.o_data_chet_i !== '0 || bus4.o_data_chet_q !== '0 || bus4.o_data_Nchet_i !== '0
            || bus4.o_data_Nchet_q !== '0 || bus4.o_counterSendData !== 3'd0) begin
            errors++;
            $display("FAIL reset_data got %h %h %h %h %0d want zeros", bus4.o_data_chet_i,
                     bus4.o_data_chet_q, bus4.o_data_Nchet_i, bus4.o_data_Nchet_q,
                     bus4.o_counterSendData);
        end
        checks++;
        if (bus1.o_ready !== 1'b1 || bus1.o_flag_complete_chet !== 1'b0) begin
            errors++;
            $display("FAIL reset_n2 got rdy=%b flag=%b want 1 0", bus1.o_ready,
                     bus1.o_flag_complete_chet);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus4.o_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready got %b want 1", bus4.o_ready);
        end
    endtask

    task automatic test_single_frame();
        int t_last;
        bus4.i_resive_chet = 1'b1; bus4.i_resive_Nchet = 1'b1;
        stream4(0, 16, t_last);
        capture_burst(40);
        checks++;
        if (cap_to || cap_n != 8) begin
            errors++;
            $display("FAIL single_len got %0d (timeout %b) want 8", cap_n, cap_to);
        end
        checks++;
        if (cap_start - t_last != 2) begin
            errors++;
            $display("FAIL single_latency got %0d want 2", cap_start - t_last);
        end
        checks++;
        if (cap_flag_neq != 0) begin
            errors++;
            $display("FAIL single_flag_align got %0d want 0", cap_flag_neq);
        end
        for (int j = 0; j < 8; j++) begin
            checks++;
            if (cap_ci[j] !== SD'(2 * j) || cap_cq[j] !== SD'(-(2 * j))
                || cap_ni[j] !== SD'(2 * j + 1) || cap_nq[j] !== SD'(-(2 * j + 1))
                || cap_cnt[j] !== 3'(j)) begin
                errors++;
                $display("FAIL single_word[%0d] got %h %h %h %h c%0d want %h %h %h %h c%0d", j,
                         cap_ci[j], cap_cq[j], cap_ni[j], cap_nq[j], cap_cnt[j], SD'(2 * j),
                         SD'(-(2 * j)), SD'(2 * j + 1), SD'(-(2 * j + 1)), j);
            end
        end
    endtask

    task automatic test_hold_overflow();
        int flags_seen;
        int end1;
        flags_seen = 0;
        bus4.i_resive_chet = 1'b0; bus4.i_resive_Nchet = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < 40; k++) begin
            bus4.i_data_i = SD'(100 + k);
            bus4.i_data_q = SD'(-(100 + k));
            bus4.i_valid  = 1'b1;
            @(posedge clk); #1;
            if (bus4.o_flag_complete_chet) flags_seen++;
            if (k == 30) begin
                checks++;
                if (bus4.o_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL hold_ready_s30 got %b want 1", bus4.o_ready);
                end
            end
            if (k == 31) begin
                checks++;
                if (bus4.o_ready !== 1'b0 || bus4.o_overflow !== 1'b0) begin
                    errors++;
                    $display("FAIL hold_ready_s31 got rdy=%b ovf=%b want 0 0", bus4.o_ready,
                             bus4.o_overflow);
                end
            end
            if (k == 32) begin
                checks++;
                if (bus4.o_overflow !== 1'b1) begin
                    errors++;
                    $display("FAIL hold_overflow got %b want 1", bus4.o_overflow);
                end
            end
        end
        bus4.i_valid = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (bus4.o_flag_complete_chet) flags_seen++;
        end
        checks++;
        if (flags_seen != 0 || bus4.o_ready !== 1'b0 || bus4.o_overflow !== 1'b1) begin
            errors++;
            $display("FAIL hold_idle got flags=%0d rdy=%b ovf=%b want 0 0 1", flags_seen,
                     bus4.o_ready, bus4.o_overflow);
        end
        bus4.i_resive_chet = 1'b1; bus4.i_resive_Nchet = 1'b1;
        capture_burst(20);
        end1 = cap_end;
        checks++;
        if (cap_to || cap_n != 8) begin
            errors++;
            $display("FAIL hold_a_len got %0d want 8", cap_n);
        end
        checks++;
        if (cap_rdy_last !== 1'b0 || cap_rdy_after !== 1'b1) begin
            errors++;
            $display("FAIL hold_ready_rise got last=%b after=%b want 0 1", cap_rdy_last,
                     cap_rdy_after);
        end
        for (int j = 0; j < 8; j++) begin
            checks++;
            if (cap_ci[j] !== SD'(100 + 2 * j) || cap_nq[j] !== SD'(-(101 + 2 * j))
                || cap_cnt[j] !== 3'(j)) begin
                errors++;
                $display("FAIL hold_a_word[%0d] got %h %h c%0d want %h %h c%0d", j, cap_ci[j],
                         cap_nq[j], cap_cnt[j], SD'(100 + 2 * j), SD'(-(101 + 2 * j)), j);
            end
        end
        capture_burst(20);
        checks++;
        if (cap_to || cap_n != 8 || cap_start - end1 != 2) begin
            errors++;
            $display("FAIL hold_b_frame got len=%0d gap=%0d want 8 2", cap_n, cap_start - end1);
        end
        for (int j = 0; j < 8; j++) begin
            checks++;
            if (cap_ci[j] !== SD'(116 + 2 * j) || cap_cq[j] !== SD'(-(116 + 2 * j))
                || cap_ni[j] !== SD'(117 + 2 * j) || cap_cnt[j] !== 3'(j)) begin
                errors++;
                $display("FAIL hold_b_word[%0d] got %h %h %h c%0d want %h %h %h c%0d", j,
                         cap_ci[j], cap_cq[j], cap_ni[j], cap_cnt[j], SD'(116 + 2 * j),
                         SD'(-(116 + 2 * j)), SD'(117 + 2 * j), j);
            end
        end
    endtask

    task automatic test_ready_gating();
        int t_last;
        int flags_seen;
        int p0;
        flags_seen = 0;
        bus4.i_resive_chet = 1'b1; bus4.i_resive_Nchet = 1'b0;
        stream4(200, 16, t_last);
        repeat (10) begin
            @(posedge clk); #1;
            if (bus4.o_flag_complete_chet) flags_seen++;
        end
        checks++;
        if (flags_seen != 0) begin
            errors++;
            $display("FAIL gating_chet_only got %0d flag cycles want 0", flags_seen);
        end
        p0 = cyc;
        bus4.i_resive_Nchet = 1'b1;
        capture_burst(20);
        checks++;
        if (cap_to || cap_n != 8 || cap_start - p0 != 2) begin
            errors++;
            $display("FAIL gating_start got len=%0d lat=%0d want 8 2", cap_n, cap_start - p0);
        end
        for (int j = 0; j < 8; j++) begin
            checks++;
            if (cap_ci[j] !== SD'(200 + 2 * j) || cap_ni[j] !== SD'(201 + 2 * j)) begin
                errors++;
                $display("FAIL gating_word[%0d] got %h %h want %h %h", j, cap_ci[j], cap_ni[j],
                         SD'(200 + 2 * j), SD'(201 + 2 * j));
            end
        end
    endtask

    task automatic test_drop_mid_send();
        int t_last;
        bus4.i_resive_chet = 1'b1; bus4.i_resive_Nchet = 1'b1;
        stream4(300, 16, t_last);
        fork
            capture_burst(40);
            begin
                for (int w = 0; w < 40 && !bus4.o_flag_complete_chet; w++) @(negedge clk);
                repeat (3) @(negedge clk);
                #1;
                bus4.i_resive_chet = 1'b0; bus4.i_resive_Nchet = 1'b0;
            end
        join
        checks++;
        if (cap_to || cap_n != 8) begin
            errors++;
            $display("FAIL drop_len got %0d want 8", cap_n);
        end
        for (int j = 0; j < 8; j++) begin
            checks++;
            if (cap_ci[j] !== SD'(300 + 2 * j) || cap_nq[j] !== SD'(-(301 + 2 * j))
                || cap_cnt[j] !== 3'(j)) begin
                errors++;
                $display("FAIL drop_word[%0d] got %h %h c%0d want %h %h c%0d", j, cap_ci[j],
                         cap_nq[j], cap_cnt[j], SD'(300 + 2 * j), SD'(-(301 + 2 * j)), j);
            end
        end
    endtask

    task automatic test_reset_mid();
        int t_last;
        int flags_seen;
        bus4.i_resive_chet = 1'b1; bus4.i_resive_Nchet = 1'b1;
        stream4(900, 5, t_last);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus4.o_ready !== 1'b1 || bus4.o_overflow !== 1'b0) begin
            errors++;
            $display("FAIL rst_partial got rdy=%b ovf=%b want 1 0", bus4.o_ready,
                     bus4.o_overflow);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        stream4(400, 16, t_last);
        for (int w = 0; w < 20 && !bus4.o_flag_complete_chet; w++) @(negedge clk);
        checks++;
        if (!bus4.o_flag_complete_chet) begin
            errors++;
            $display("FAIL rst_frame_timeout got flag 0 want 1");
        end
        for (int j = 0; j < 5; j++) begin
            checks++;
            if (bus4.o_data_chet_i !== SD'(400 + 2 * j) || bus4.o_data_Nchet_i !== SD'(401 + 2 * j)
                || bus4.o_counterSendData !== 3'(j)) begin
                errors++;
                $display("FAIL rst_pre_word[%0d] got %h %h c%0d want %h %h c%0d", j,
                         bus4.o_data_chet_i, bus4.o_data_Nchet_i, bus4.o_counterSendData,
                         SD'(400 + 2 * j), SD'(401 + 2 * j), j);
            end
            if (j < 4) @(negedge clk);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus4.o_flag_complete_chet !== 1'b0 || bus4.o_flag_complete_Nchet !== 1'b0
            || bus4.o_ready !== 1'b1 || bus4.o_overflow !== 1'b0
            || bus4.o_counterSendData !== 3'd0 || bus4.o_data_chet_i !== '0) begin
            errors++;
            $display("FAIL rst_mid_send got f=%b%b rdy=%b ovf=%b c%0d d=%h want 00 1 0 c0 0",
                     bus4.o_flag_complete_chet, bus4.o_flag_complete_Nchet, bus4.o_ready,
                     bus4.o_overflow, bus4.o_counterSendData, bus4.o_data_chet_i);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        stream4(500, 16, t_last);
        capture_burst(40);
        checks++;
        if (cap_to || cap_n != 8 || cap_start - t_last != 2) begin
            errors++;
            $display("FAIL rst_after_frame got len=%0d lat=%0d want 8 2", cap_n,
                     cap_start - t_last);
        end
        for (int j = 0; j < 8; j++) begin
            checks++;
            if (cap_ci[j] !== SD'(500 + 2 * j) || cap_cq[j] !== SD'(-(500 + 2 * j))
                || cap_ni[j] !== SD'(501 + 2 * j) || cap_cnt[j] !== 3'(j)) begin
                errors++;
                $display("FAIL rst_after_word[%0d] got %h %h %h c%0d want %h %h %h c%0d", j,
                         cap_ci[j], cap_cq[j], cap_ni[j], cap_cnt[j], SD'(500 + 2 * j),
                         SD'(-(500 + 2 * j)), SD'(501 + 2 * j), j);
            end
        end
        flags_seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus4.o_flag_complete_chet) flags_seen++;
        end
        checks++;
        if (flags_seen != 0) begin
            errors++;
            $display("FAIL rst_no_stale_frame got %0d flag cycles want 0", flags_seen);
        end
    endtask

    task automatic test_nfft2();
        int t_last;
        int t_start;
        bus1.i_resive_chet = 1'b1; bus1.i_resive_Nchet = 1'b1;
        @(posedge clk); #1;
        bus1.i_data_i = SD'(3); bus1.i_data_q = SD'(-3); bus1.i_valid = 1'b1;
        @(posedge clk); #1;
        bus1.i_data_i = SD'(7); bus1.i_data_q = SD'(-7);
        @(posedge clk); #1;
        bus1.i_valid = 1'b0;
        t_last = cyc;
        for (int w = 0; w < 10 && !bus1.o_flag_complete_chet; w++) @(negedge clk);
        t_start = cyc;
        checks++;
        if (bus1.o_flag_complete_chet !== 1'b1 || bus1.o_flag_complete_Nchet !== 1'b1
            || t_start - t_last != 2) begin
            errors++;
            $display("FAIL n2_start got f=%b%b lat=%0d want 11 2", bus1.o_flag_complete_chet,
                     bus1.o_flag_complete_Nchet, t_start - t_last);
        end
        checks++;
        if (bus1.o_data_chet_i !== SD'(3) || bus1.o_data_chet_q !== SD'(-3)
            || bus1.o_data_Nchet_i !== SD'(7) || bus1.o_data_Nchet_q !== SD'(-7)
            || bus1.o_counterSendData !== 1'b0) begin
            errors++;
            $display("FAIL n2_word got %h %h %h %h c%0d want 0003 fffd 0007 fff9 c0",
                     bus1.o_data_chet_i, bus1.o_data_chet_q, bus1.o_data_Nchet_i,
                     bus1.o_data_Nchet_q, bus1.o_counterSendData);
        end
        @(negedge clk);
        checks++;
        if (bus1.o_flag_complete_chet !== 1'b0 || bus1.o_data_chet_i !== SD'(3)) begin
            errors++;
            $display("FAIL n2_single_cycle got flag=%b hold=%h want 0 0003",
                     bus1.o_flag_complete_chet, bus1.o_data_chet_i);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_hold_overflow();
        test_ready_gating();
        test_drop_mid_send();
        test_reset_mid();
        test_nfft2();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/split_mfft_to_two_sfft.md
Name: split_mFFT_to_two_sFFT

Overview:
- Input-side counterpart of the two-sub-FFT merge stage: decimation-in-time splitter in front of the two half-size FFTs.
- Accepts a serial stream of NFFT complex samples and de-interleaves it: even-index samples go to the "chet" sub-FFT, odd-index samples to the "Nchet" sub-FFT.
- Double-buffered (two frame banks): input collection of frame n+1 overlaps streaming of frame n to both sub-FFTs in parallel.
- Output framing matches the merge stage's input convention: complete flag high for NFFT/2 cycles, one word per cycle, both halves aligned.

Parameters:
- SIZE_BUFFER, 4, log2(NFFT); minimum 1; NFFT = 1 << SIZE_BUFFER.
- SIZE_DATA, 16, width of each I/Q component; passed through unmodified.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_data_i  in  SIZE_DATA  input sample, real part.
- i_data_q  in  SIZE_DATA  input sample, imaginary part.
- i_valid  in  1  input sample valid.
- o_ready  out  1  block can accept a sample this cycle.
- i_resive_chet  in  1  chet sub-FFT can take a whole frame.
- i_resive_Nchet  in  1  Nchet sub-FFT can take a whole frame.
- o_data_chet_i / o_data_chet_q  out  SIZE_DATA each  even-index sample to the chet sub-FFT.
- o_data_Nchet_i / o_data_Nchet_q  out  SIZE_DATA each  odd-index sample to the Nchet sub-FFT.
- o_flag_complete_chet  out  1  chet output word valid.
- o_flag_complete_Nchet  out  1  Nchet output word valid; always equal to o_flag_complete_chet.
- o_counterSendData  out  SIZE_BUFFER-1 (1 when SIZE_BUFFER=1)  index of the word currently on the outputs.
- o_overflow  out  1  sticky: a sample arrived while o_ready was low.

Behaviour:
- Reset (async assert, sync release): both banks empty, write bank = 0, read bank = 0, write counter = 0, state IDLE.
  - Output reset values: o_ready=1, both flags=0, all data outputs=0, o_counterSendData=0, o_overflow=0.
  - Reset asserted mid-frame or mid-send discards all buffered data; no partial frame is ever emitted.
- Write side:
  - A sample is accepted when i_valid & o_ready. Frame index k = write counter (SIZE_BUFFER bits).
  - k even -> chet half of the write bank, address k>>1. k odd -> Nchet half, address k>>1.
  - On accepting k = NFFT-1: the write bank is marked full, the write bank index toggles, and the counter wraps to 0.
  - o_ready is registered and equals "current write bank not full".
  - i_valid while o_ready=0: sample dropped, counter unchanged, o_overflow set until reset.
- Read side FSM, states IDLE and SEND:
  - IDLE -> SEND when the read bank is full and i_resive_chet & i_resive_Nchet are both high in the same cycle.
  - Both ready inputs are sampled only at the IDLE->SEND decision. Once SEND starts, it runs NFFT/2 consecutive cycles with no stall.
  - In SEND, cycle j (0..NFFT/2-1): outputs are chet[j] and Nchet[j] (i.e. x[2j] and x[2j+1]), both flags = 1, o_counterSendData = j. Outputs are registered.
  - After word NFFT/2-1: read bank marked empty, read bank toggles, state returns to IDLE, flags drop to 0 on the next cycle.
  - Data outputs hold their last value when the flags are low.
- Latency:
  - Last sample of a frame accepted at edge T -> bank full after T.
  - With both ready inputs high, the decision is made at edge T+1 and the first output word is valid in cycle T+2.
  - Minimum gap between consecutive frames' flag bursts is 1 idle cycle.
- Simultaneous events:
  - A bank freed on the last SEND cycle is writable from the next cycle: o_ready rises 1 cycle after the last output word.
  - Write and read of different banks in the same cycle are independent.
  - With both banks full, o_ready=0 until a SEND completes.
- Sizing and storage:
  - SIZE_BUFFER=1 (NFFT=2): one word per half, SEND lasts 1 cycle.
  - Storage is 2 banks x 2 halves x NFFT/2 words x 2*SIZE_DATA bits, inferable as RAM with registered read. Read address is issued one cycle ahead to meet the output timing.

Test Plan:
- Reset, then NFFT=16 samples x[k] = k (I) / -k (Q) back-to-back, ready inputs high -> flags high for 8 cycles starting 2 cycles after the last accept; chet_i = 0,2,…,14; Nchet_i = 1,3,…,15; Q negated; o_counterSendData counts 0..7.
- Ready inputs low for 20 cycles after frame 0; stream 40 samples continuously -> frame 0 held; frame 1 fills bank 1; o_ready drops after sample 31 and o_overflow=1 on the next sample. Raising both ready inputs emits frame 0, then frame 1 in order with no corruption.
- Only i_resive_chet high -> no SEND starts. Raising i_resive_Nchet -> SEND starts on that cycle's decision.
- Drop both ready inputs mid-SEND -> burst still completes all 8 words.
- Assert i_reset after 5 samples, then after 5 more words of an active SEND -> flags drop immediately, o_ready=1, o_overflow=0. The next full frame is emitted correctly with indices restarting at 0.
- SIZE_BUFFER=1, samples (3,7) -> a single-cycle burst: chet=3, Nchet=7, o_counterSendData=0.
